// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and multicycle sequencer for the 5-stage F/D/X/M/W core.
// Handles three jobs:
//   - load-use stalls between D and X,
//   - branch flushes of F/D and D/X,
//   - start/ready sequencing of the shared mult/div unit, which freezes
//     the front of the pipe while the unit is working.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       uses_rs2_d,
    input  logic [4:0] rd_x,
    input  logic       is_load_x,
    input  logic       is_md_x,
    input  logic       md_is_div_x,
    input  logic       branch_taken_x,
    input  logic       md_ready,
    input  logic       md_exc_in,
    output logic       stall_pc,
    output logic       stall_fd,
    output logic       stall_dx,
    output logic       flush_fd,
    output logic       flush_dx,
    output logic       bubble_xm,
    output logic       ctrl_mult,
    output logic       ctrl_div,
    output logic       md_busy,
    output logic       md_done,
    output logic       md_exc,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exc_q, exc_d;
    logic             terr_q, terr_d;
    logic             freeze;
    logic             load_use;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = is_load_x && (rd_x != 5'd0) &&
                      ((rd_x == rs1_d) || (uses_rs2_d && (rd_x == rs2_d)));

    // State register: sequencer state, busy counter, captured exception, sticky timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state and output decode; md sequencing outranks branch, which outranks load-use.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        exc_d       = exc_q;
        terr_d      = terr_q;
        freeze      = 1'b0;
        stall_pc    = 1'b0;
        stall_fd    = 1'b0;
        stall_dx    = 1'b0;
        flush_fd    = 1'b0;
        flush_dx    = 1'b0;
        bubble_xm   = 1'b0;
        ctrl_mult   = 1'b0;
        ctrl_div    = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        md_exc      = 1'b0;
        timeout_err = terr_q;

        case (state_q)
            ST_IDLE: begin
                if (is_md_x) begin
                    ctrl_div  = md_is_div_x;
                    ctrl_mult = !md_is_div_x;
                    freeze    = 1'b1;
                    state_d   = ST_BUSY;
                    cnt_d     = '0;
                end
            end
            ST_BUSY: begin
                freeze  = 1'b1;
                md_busy = 1'b1;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // A real result wins over a timeout landing on the same cycle.
                if (md_ready) begin
                    state_d = ST_DONE;
                    exc_d   = md_exc_in;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    exc_d   = 1'b1;
                    terr_d  = 1'b1;
                end
            end
            ST_DONE: begin
                // Stalls drop here so X/M captures the result and X moves on;
                // the finished instruction therefore cannot restart.
                md_done = 1'b1;
                md_exc  = exc_q;
                state_d = ST_IDLE;
                exc_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (freeze) begin
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            stall_dx  = 1'b1;
            bubble_xm = 1'b1;
        end else if (branch_taken_x) begin
            flush_fd = 1'b1;
            flush_dx = 1'b1;
        end else if (load_use) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_dx = 1'b1;
        end

        // Outputs are forced low for as long as reset is held, whatever the inputs do.
        if (!reset) begin
            stall_pc    = 1'b0;
            stall_fd    = 1'b0;
            stall_dx    = 1'b0;
            flush_fd    = 1'b0;
            flush_dx    = 1'b0;
            bubble_xm   = 1'b0;
            ctrl_mult   = 1'b0;
            ctrl_div    = 1'b0;
            md_busy     = 1'b0;
            md_done     = 1'b0;
            md_exc      = 1'b0;
            timeout_err = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: each cycle's expected output vector
// is queued when the stimulus is driven and popped when the outputs are sampled.
module tb_hazard_stall_ctrl;

    // Output vector bit positions (MSB first, matching outs()).
    localparam logic [11:0] O_SPC  = 12'h800;
    localparam logic [11:0] O_SFD  = 12'h400;
    localparam logic [11:0] O_SDX  = 12'h200;
    localparam logic [11:0] O_FFD  = 12'h100;
    localparam logic [11:0] O_FDX  = 12'h080;
    localparam logic [11:0] O_BXM  = 12'h040;
    localparam logic [11:0] O_MUL  = 12'h020;
    localparam logic [11:0] O_DIV  = 12'h010;
    localparam logic [11:0] O_BUSY = 12'h008;
    localparam logic [11:0] O_DONE = 12'h004;
    localparam logic [11:0] O_EXC  = 12'h002;
    localparam logic [11:0] O_TERR = 12'h001;
    localparam logic [11:0] O_FRZ  = O_SPC | O_SFD | O_SDX | O_BXM;
    localparam logic [11:0] O_LU   = O_SPC | O_SFD | O_FDX;
    localparam logic [11:0] O_BR   = O_FFD | O_FDX;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs1_d, rs2_d, rd_x;
    logic       uses_rs2_d, is_load_x, is_md_x, md_is_div_x;
    logic       branch_taken_x, md_ready, md_exc_in;
    logic       stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, bubble_xm;
    logic       ctrl_mult, ctrl_div, md_busy, md_done, md_exc, timeout_err;

    typedef struct packed {
        logic       md;
        logic       dv;
        logic       rdy;
        logic       ex;
        logic       br;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic [11:0] exp;
    } step_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got, e;
    step_t       tab[$];

    hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs2_d(uses_rs2_d), .rd_x(rd_x),
        .is_load_x(is_load_x), .is_md_x(is_md_x), .md_is_div_x(md_is_div_x),
        .branch_taken_x(branch_taken_x), .md_ready(md_ready), .md_exc_in(md_exc_in),
        .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
        .flush_fd(flush_fd), .flush_dx(flush_dx), .bubble_xm(bubble_xm),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_busy(md_busy),
        .md_done(md_done), .md_exc(md_exc), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] outs();
        return {stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, bubble_xm,
                ctrl_mult, ctrl_div, md_busy, md_done, md_exc, timeout_err};
    endfunction

    function automatic step_t mk(input logic md, input logic dv, input logic rdy,
                                 input logic ex, input logic br, input logic ld,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [11:0] exp);
        step_t s;
        s.md = md; s.dv = dv; s.rdy = rdy; s.ex = ex; s.br = br; s.ld = ld;
        s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u2 = u2; s.exp = exp;
        return s;
    endfunction

    // Drives one cycle's inputs and queues the outputs expected for them.
    task automatic drive_step(input step_t s);
        is_md_x = s.md; md_is_div_x = s.dv; md_ready = s.rdy; md_exc_in = s.ex;
        branch_taken_x = s.br; is_load_x = s.ld; rd_x = s.rd;
        rs1_d = s.rs1; rs2_d = s.rs2; uses_rs2_d = s.u2;
        exp_q.push_back(s.exp);
    endtask

    task automatic clear_inputs();
        drive_step(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 12'h000));
        void'(exp_q.pop_back());
    endtask

    task automatic test_reset();
        // Held in reset with every trigger active: outputs must all stay low.
        for (int i = 0; i < 2; i++) begin
            drive_step(mk(1, 1, 1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 12'h000));
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL reset_held cyc%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_step(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 12'h000));
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL reset_release cyc%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_mul();
        // Start pulse, 5 BUSY cycles with md_ready on the last, then DONE.
        for (int i = 0; i < 8; i++) begin
            drive_step(mk(i < 7, 0, i == 5, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0,
                          (i == 0) ? (O_FRZ | O_MUL) : (i <= 5) ? (O_FRZ | O_BUSY) :
                          (i == 6) ? O_DONE : 12'h000));
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL mul cyc%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_div_exc();
        // md_ready with exception after 32 cycles; stray md_ready in DONE/IDLE is ignored.
        for (int i = 0; i < 35; i++) begin
            drive_step(mk(i < 34, 1, i >= 32, (i == 32) || (i == 33), 0, 0, 5'd0, 5'd0, 5'd0, 0,
                          (i == 0) ? (O_FRZ | O_DIV) : (i <= 32) ? (O_FRZ | O_BUSY) :
                          (i == 33) ? (O_DONE | O_EXC) : 12'h000));
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL div_exc cyc%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        tab = {};
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 5'd5,  5'd5,  5'd0, 0, O_LU));   // rs1 match
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0, 0, 12'h000)); // stall lasts one cycle
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0, 1, 12'h000)); // x0 never triggers
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 5'd5,  5'd3,  5'd5, 0, 12'h000)); // rs2 not read
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 5'd5,  5'd3,  5'd5, 1, O_LU));   // rs2 match
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 5'd5,  5'd5,  5'd5, 1, 12'h000)); // not a load
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 5'd31, 5'd31, 5'd2, 0, O_LU));   // top register
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 5'd7,  5'd6,  5'd8, 1, 12'h000)); // no match
        foreach (tab[i]) begin
            drive_step(tab[i]);
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL load_use row%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        tab = {};
        tab.push_back(mk(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, O_BR));            // plain branch
        tab.push_back(mk(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, O_BR));            // branch beats load-use
        tab.push_back(mk(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, O_FRZ | O_MUL));   // md start beats branch
        tab.push_back(mk(1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, O_FRZ | O_BUSY));  // ignored in BUSY
        tab.push_back(mk(1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, O_FRZ | O_BUSY));
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_DONE));
        tab.push_back(mk(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, O_BR));            // branch works again
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 12'h000));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL branch row%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        tab = {};
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_FRZ | O_MUL));
        tab.push_back(mk(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_FRZ | O_BUSY));
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_DONE));          // no restart in DONE
        tab.push_back(mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_FRZ | O_DIV));   // next md instruction
        tab.push_back(mk(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_FRZ | O_BUSY));
        tab.push_back(mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_DONE));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 12'h000));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL back_to_back row%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
    endtask

    // ready_at = 40 lands on the timeout cycle (ready must win); -1 never answers.
    task automatic test_timeout(input int ready_at, input string name);
        logic timed_out;
        timed_out = (ready_at < 0);
        for (int i = 0; i < 44; i++) begin
            drive_step(mk(i <= 41, 1, i == ready_at, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0,
                          (i == 0) ? (O_FRZ | O_DIV) : (i <= 40) ? (O_FRZ | O_BUSY) :
                          (i == 41) ? (timed_out ? (O_DONE | O_EXC | O_TERR) : O_DONE) :
                          (timed_out ? O_TERR : 12'h000)));
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL %s cyc%0d: got %03h expected %03h", name, i, got, e); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid_busy();
        // timeout_err is still set from the previous test.
        for (int i = 0; i < 3; i++) begin
            drive_step(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0,
                          (i == 0) ? (O_FRZ | O_MUL | O_TERR) : (O_FRZ | O_BUSY | O_TERR)));
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL mid_busy_pre cyc%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
        // Assert reset between edges: outputs must drop without a clock edge.
        drive_step(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 12'h000));
        #2 reset = 1'b0;
        #1;
        got = outs(); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL mid_busy_async: got %03h expected %03h", got, e); end
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) reset = 1'b1;
            // md_ready keeps arriving, but the abandoned op must not complete.
            drive_step(mk(i < 2, 0, i < 3, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 12'h000));
            @(negedge clock);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL mid_busy_post cyc%0d: got %03h expected %03h", i, got, e); end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_mul();
        test_div_exc();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_timeout(40, "ready_at_timeout");
        test_timeout(-1, "timeout");
        test_reset_mid_busy();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
